// File: rtl/lsu_stbuf.sv
`timescale 1ns/1ps
// Store buffer between the dc3 store pipe and the DCCM write port.
// A circular FIFO of committed stores that drains the oldest entry on each port ack,
// and returns byte-granular store-to-load forwarding data one cycle after a dc3 lookup.
module lsu_stbuf #(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned ADDR_W         = 16,
  parameter bit          CHECK_OVERFLOW = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     store_stbuf_reqvld_dc3,
  input  logic                     stbuf_flush_dc3,
  input  logic [ADDR_W-1:0]        lsu_addr_dc3,
  input  logic [31:0]              store_data_dc3,
  input  logic [3:0]               store_byteen_dc3,
  input  logic                     load_stbuf_reqvld_dc3,
  input  logic [3:0]               load_byteen_dc3,
  input  logic                     stbuf_ack_any,
  output logic                     stbuf_reqvld_any,
  output logic                     stbuf_reqvld_flushed_any,
  output logic [ADDR_W-1:0]        stbuf_addr_any,
  output logic [31:0]              stbuf_data_any,
  output logic [3:0]               stbuf_byteen_any,
  output logic                     lsu_stbuf_empty_any,
  output logic                     lsu_stbuf_full_any,
  output logic [$clog2(DEPTH):0]   stbuf_count,
  output logic [3:0]               stbuf_fwdbyteen_dc4,
  output logic [31:0]              stbuf_fwddata_dc4
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q   [DEPTH];
  logic [31:0]       data_q   [DEPTH];
  logic [3:0]        byteen_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic              flushed_q;
  logic [3:0]        fwd_be_q;
  logic [31:0]       fwd_data_q;

  logic              alloc_c;
  logic              ack_c;
  logic [3:0]        fwd_be_c;
  logic [31:0]       fwd_data_c;
  logic [PTR_W-1:0]  idx_c;

  // Status and head-of-queue drain request.
  assign lsu_stbuf_empty_any      = (count_q == '0);
  assign lsu_stbuf_full_any       = (count_q == CNT_W'(DEPTH));
  assign stbuf_count              = count_q;
  assign stbuf_reqvld_any         = valid_q[rd_ptr_q];
  assign stbuf_addr_any           = addr_q[rd_ptr_q];
  assign stbuf_data_any           = data_q[rd_ptr_q];
  assign stbuf_byteen_any         = byteen_q[rd_ptr_q];
  assign stbuf_reqvld_flushed_any = flushed_q;
  assign stbuf_fwdbyteen_dc4      = fwd_be_q;
  assign stbuf_fwddata_dc4        = fwd_data_q;

  // Full is judged on the current count, so a same-cycle ack cannot make room.
  assign alloc_c = store_stbuf_reqvld_dc3 & ~stbuf_flush_dc3 & ~lsu_stbuf_full_any;
  assign ack_c   = stbuf_ack_any & stbuf_reqvld_any;

  // Entry storage: retire the head on ack, write the tail on allocation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        addr_q[i]   <= '0;
        data_q[i]   <= '0;
        byteen_q[i] <= '0;
      end
    end else begin
      if (ack_c) valid_q[rd_ptr_q] <= 1'b0;
      if (alloc_c) begin
        valid_q[wr_ptr_q]  <= 1'b1;
        addr_q[wr_ptr_q]   <= lsu_addr_dc3;
        data_q[wr_ptr_q]   <= store_data_dc3;
        byteen_q[wr_ptr_q] <= store_byteen_dc3;
      end
    end
  end

  // Pointers, occupancy and the flushed-allocation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      flushed_q <= 1'b0;
    end else begin
      flushed_q <= store_stbuf_reqvld_dc3 & stbuf_flush_dc3;
      if (alloc_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (ack_c)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({alloc_c, ack_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Forwarding search: walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    fwd_be_c   = '0;
    fwd_data_c = '0;
    idx_c      = rd_ptr_q;
    for (int i = 0; i < int'(DEPTH); i++) begin
      idx_c = rd_ptr_q + PTR_W'(i);
      for (int b = 0; b < 4; b++) begin
        if (load_stbuf_reqvld_dc3 && valid_q[idx_c] && (addr_q[idx_c] == lsu_addr_dc3) &&
            byteen_q[idx_c][b] && load_byteen_dc3[b]) begin
          fwd_be_c[b]          = 1'b1;
          fwd_data_c[b*8 +: 8] = data_q[idx_c][b*8 +: 8];
        end
      end
    end
  end

  // Forwarding result register; loads zero when there is no lookup.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_be_q   <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_be_q   <= fwd_be_c;
      fwd_data_q <= fwd_data_c;
    end
  end

  // The dc3 pipe must freeze on full; an allocation attempt while full is a protocol error.
  if (CHECK_OVERFLOW) begin : g_ovf_chk
    a_no_alloc_when_full : assert property (@(posedge clk) disable iff (rst)
      !(store_stbuf_reqvld_dc3 && !stbuf_flush_dc3 && lsu_stbuf_full_any));
  end

endmodule
